// File: rtl/celera_dac_softstart_seq.sv
// Soft-start sequencer for a 6-bit ladder DAC: powers the DAC, then walks the code one LSB per
// settled step toward target. Define CELERA_SS_RAMPDOWN_EN to ramp back to 0 on disable.
module celera_dac_softstart_seq #(
  parameter int unsigned TMO  = 16,
  parameter int unsigned WAKE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [5:0] target,
  input  logic [7:0] step_div,
  input  logic       ok_dac,
  output logic [5:0] i,
  output logic       strobe_dac,
  output logic       global_dac,
  output logic       busy,
  output logic       done,
  output logic       fault
);

  typedef enum logic [2:0] {
    StIdle,
    StWake,
    StStep,
    StSettle,
    StHold,
    StDone,
    StFault
`ifdef CELERA_SS_RAMPDOWN_EN
    , StRampdn
`endif
  } state_e;

  // The strobe cycle counts toward the settle timeout, so SETTLE itself lasts TMO-1 cycles.
  localparam logic [7:0] WakeLast = 8'(WAKE - 1);
  localparam logic [7:0] TmoLast  = 8'(TMO - 2);

  state_e     state_q;
  logic [7:0] cnt_q;

  logic       run_state;
  logic       step_due;
  logic       up_req;
  logic [5:0] i_up;
  logic       go_up;
`ifdef CELERA_SS_RAMPDOWN_EN
  logic       down_q;
  logic       go_dn;
`else
  logic       go_off;
`endif

  always_comb begin
    up_req    = (i != target);
    i_up      = (i < target) ? i + 6'd1 : i - 6'd1;
    run_state = (state_q == StWake) || (state_q == StStep) || (state_q == StSettle) ||
                (state_q == StHold) || (state_q == StDone);
    step_due  = ((state_q == StWake) && (cnt_q == WakeLast)) ||
                ((state_q == StHold) && (cnt_q == 8'd0)) ||
                ((state_q == StDone) && up_req);
    go_up     = 1'b0;
`ifdef CELERA_SS_RAMPDOWN_EN
    go_dn     = 1'b0;
    // While already ramping down, en only picks the direction at the next step boundary.
    if (run_state && !en && !down_q) begin
      go_dn = 1'b1;
    end else if (step_due) begin
      go_up = en;
      go_dn = !en;
    end
`else
    go_off    = run_state && !en;
    go_up     = step_due && en;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= 8'd0;
      i          <= 6'd0;
      strobe_dac <= 1'b0;
      global_dac <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
`ifdef CELERA_SS_RAMPDOWN_EN
      down_q     <= 1'b0;
`endif
    end else begin
      strobe_dac <= 1'b0;
`ifdef CELERA_SS_RAMPDOWN_EN
      if (go_dn) begin
        done <= 1'b0;
        if (i == 6'd0) begin
          state_q    <= StIdle;
          global_dac <= 1'b0;
          busy       <= 1'b0;
          down_q     <= 1'b0;
        end else begin
          state_q    <= StRampdn;
          i          <= i - 6'd1;
          strobe_dac <= 1'b1;
          cnt_q      <= 8'd0;
          busy       <= 1'b1;
          down_q     <= 1'b1;
        end
      end
`else
      if (go_off) begin
        state_q    <= StIdle;
        i          <= 6'd0;
        global_dac <= 1'b0;
        busy       <= 1'b0;
        done       <= 1'b0;
      end
`endif
      else if (go_up) begin
        // Code already at target: a strobe-less STEP cycle, then DONE.
        state_q <= StStep;
        cnt_q   <= 8'd0;
        busy    <= 1'b1;
        done    <= 1'b0;
`ifdef CELERA_SS_RAMPDOWN_EN
        down_q  <= 1'b0;
`endif
        if (up_req) begin
          i          <= i_up;
          strobe_dac <= 1'b1;
        end
      end else begin
        case (state_q)
          StIdle: begin
            i          <= 6'd0;
            global_dac <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fault      <= 1'b0;
            cnt_q      <= 8'd0;
            if (en) begin
              state_q    <= StWake;
              global_dac <= 1'b1;
              busy       <= 1'b1;
            end
          end
          StWake: cnt_q <= cnt_q + 8'd1;
          StStep: begin
            if (strobe_dac) begin
              state_q <= StSettle;
            end else begin
              state_q <= StDone;
              done    <= 1'b1;
              busy    <= 1'b0;
            end
          end
          StSettle: begin
            if (ok_dac) begin
              state_q <= StHold;
              cnt_q   <= step_div;
            end else if (cnt_q == TmoLast) begin
              state_q    <= StFault;
              fault      <= 1'b1;
              i          <= 6'd0;
              global_dac <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          StHold: cnt_q <= cnt_q - 8'd1;
          StDone: done <= 1'b1;
          StFault: begin
            if (!en) begin
              state_q <= StIdle;
              fault   <= 1'b0;
            end
          end
`ifdef CELERA_SS_RAMPDOWN_EN
          // The down strobe still has to settle; direction is re-chosen at the end of HOLD.
          StRampdn: state_q <= StSettle;
`endif
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: doc/celera_dac_softstart_seq.md
CELERA_DAC_SOFTSTART_SEQ -- requirements
Module: celera_dac_softstart_seq

Interface
REQ-001 Parameter: TMO, 16, settle timeout in clk cycles after strobe_dac (range 2..255).
REQ-002 Parameter: WAKE, 4, cycles global_dac is held high before the first code strobe (range 1..255).
REQ-003 Port: clk  input  1  single clock; all logic on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: en  input  1  soft-start request; level-sensitive.
REQ-006 Port: target  input  6  final ladder code, unsigned.
REQ-007 Port: step_div  input  8  extra hold cycles between code steps.
REQ-008 Port: ok_dac  input  1  settle acknowledge returned by the 6-bit ladder DAC.
REQ-009 Port: i  output  6  ladder code driven to the DAC.
REQ-010 Port: strobe_dac  output  1  one-cycle load pulse qualifying i.
REQ-011 Port: global_dac  output  1  DAC/buffer power enable.
REQ-012 Port: busy  output  1  sequence in progress.
REQ-013 Port: done  output  1  code equals target and the DAC has settled.
REQ-014 Port: fault  output  1  settle timeout occurred; sticky.

Function
REQ-015 FSM states SHALL be IDLE, WAKE, STEP, SETTLE, HOLD, DONE, FAULT, plus RAMPDN when the Configuration macro is defined.
REQ-016 IDLE: outputs i=0, global_dac=0, busy=0; en=1 -> WAKE.
REQ-017 WAKE: global_dac=1, busy=1; after exactly WAKE cycles -> STEP.
REQ-018 STEP: target sampled; if i==target -> DONE with no strobe; otherwise i moves by +1 or -1 toward target and strobe_dac=1 for exactly that one cycle -> SETTLE.
REQ-019 i SHALL change only in the strobe_dac cycle and SHALL remain stable until the next strobe.
REQ-020 SETTLE: ok_dac sampled from the cycle after the strobe; ok_dac=1 -> HOLD with the hold counter loaded from step_div.
REQ-021 SETTLE: if TMO cycles elapse without ok_dac=1 -> FAULT.
REQ-022 HOLD: the counter decrements each cycle, and the block goes to STEP on the cycle the counter reads 0; step_div=0 SHALL give STEP on the next cycle.
REQ-023 Each step therefore SHALL take at least 3+step_div cycles (STEP, SETTLE with ok, HOLD).
REQ-024 DONE: done=1, busy=0, global_dac=1; a change in target SHALL cause DONE -> STEP, which re-ramps and clears done.
REQ-025 FAULT: fault=1, i=0, global_dac=0, busy=0, no strobe; it is left only by en=0 -> IDLE, and fault clears in IDLE.
REQ-026 en=0 in WAKE, STEP, SETTLE, HOLD or DONE: behaviour SHALL be per REQ-030/031.
REQ-027 When en falls on the cycle ok_dac rises in SETTLE, en SHALL take priority.
REQ-028 The code SHALL never wrap: no decrement below 0 and no increment above 63.

Reset
REQ-029 rst=1 SHALL force IDLE, i=0, strobe_dac=0, global_dac=0, busy=0, done=0, fault=0, and clear all counters on the next clk edge; rst SHALL override en mid-ramp.

Configuration
REQ-030 Macro CELERA_SS_RAMPDOWN_EN defined: en=0 -> RAMPDN, which steps i toward 0 using the STEP/SETTLE/HOLD timing with busy=1, and enters IDLE (global_dac=0) when i==0; a timeout here SHALL go to FAULT; en=1 during RAMPDN -> STEP toward target.
REQ-031 Macro not defined: en=0 -> IDLE on the next edge, i=0 and global_dac=0 immediately, no strobe.

Verification
REQ-032 Ramp: WAKE=4, target=5, step_div=2, ok_dac returns 1 cycle after each strobe -> 5 strobes with i=1..5, strobes spaced 5 cycles apart, done=1 after i=5.
REQ-033 Timeout: TMO=16, ok_dac held 0 -> fault=1 exactly 16 cycles after the first strobe, with i=0 and global_dac=0; en=0 -> IDLE with fault=0.
REQ-034 Retarget: in DONE at i=5, target=2 -> strobes with i=4, 3, 2, then done=1 again.
REQ-035 Disable mid-ramp at i=3: with CELERA_SS_RAMPDOWN_EN -> strobes with i=2, 1, 0, then global_dac=0; without the macro -> i=0 and global_dac=0 on the next cycle, with no strobe.
REQ-036 rst=1 during SETTLE at i=30 -> on the next edge all outputs are 0 and the state is IDLE; target=0 with en=1 -> DONE after WAKE with no strobe.
